// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU-control stage: opcode/funct
// values, ALU control codes, ALUOp values and the sequencing FSM states.
package alu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SUBI  = 6'b111111;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_BGEZ = 4'b1110;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decoder: opcode table first, then ALUOp,
// then the R-type funct table; anything unmatched is flagged illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_CODE = 4'b0010
) (
  input  logic [1:0] aluop,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       is_mul,
  output logic       is_div,
  output logic       illegal
);

  always_comb begin
    code    = ALU_ADD;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    illegal = 1'b0;
    if (opcode != OP_RTYPE) begin
      case (opcode)
        OP_ADDI, OP_LB, OP_LH, OP_LW,
        OP_SB, OP_SH, OP_SW:           code = ALU_ADD;
        OP_SUBI, OP_BEQ:               code = ALU_SUB;
        OP_ANDI:                       code = ALU_AND;
        OP_ORI:                        code = ALU_OR;
        OP_SLTI:                       code = ALU_SLT;
        OP_LUI:                        code = ALU_LUI;
        OP_BGEZ:                       code = ALU_BGEZ;
        OP_BNE:                        code = ALU_BNE;
        default:                       illegal = 1'b1;
      endcase
    end else if (aluop == ALUOP_ADD) begin
      code = ALU_ADD;
    end else if (aluop == ALUOP_SUB) begin
      code = ALU_SUB;
    end else if (aluop == ALUOP_FUNCT) begin
      case (funct)
        FN_ADD:            code = ALU_ADD;
        FN_SUB:            code = ALU_SUB;
        FN_AND:            code = ALU_AND;
        FN_OR:             code = ALU_OR;
        FN_SLT:            code = ALU_SLT;
        FN_NOR:            code = ALU_NOR;
        FN_MULT, FN_MULTU: begin
          code   = ALU_MUL;
          is_mul = 1'b1;
        end
        FN_DIV, FN_DIVU:   begin
          code   = ALU_DIV;
          is_div = 1'b1;
        end
        default:           illegal = 1'b1;
      endcase
    end else begin
      illegal = 1'b1;
    end
    if (illegal) begin
      code = ILLEGAL_CODE;
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control stage: valid/ready output register, MDU busy
// sequencing with stall, flush and illegal-instruction reporting.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int          CTRL_W       = 4,
  parameter int          MUL_CYCLES   = 4,
  parameter int          DIV_CYCLES   = 32,
  parameter logic [3:0]  ILLEGAL_CODE = 4'b0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic              stall
);

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [3:0] dec_code;
  logic       dec_mul, dec_div, dec_illegal;
  logic       accept;

  alu_ctrl_decode #(
    .ILLEGAL_CODE(ILLEGAL_CODE)
  ) u_decode (
    .aluop  (aluop),
    .opcode (opcode),
    .funct  (funct),
    .code   (dec_code),
    .is_mul (dec_mul),
    .is_div (dec_div),
    .illegal(dec_illegal)
  );

  assign accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // BUSY lasts exactly the loaded count: the final decrement to zero and
  // the return to IDLE happen on the same edge.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (flush) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (dec_mul || dec_div)) begin
            count_nxt = dec_mul ? MUL_LOAD : DIV_LOAD;
            state_nxt = (count_nxt != '0) ? ST_BUSY : ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (count <= 8'd1) begin
            count_nxt = '0;
            state_nxt = ST_IDLE;
          end else begin
            count_nxt = count - 8'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    stall    = !in_ready;
    mdu_busy = (state == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_ctrl  <= '0;
      illegal   <= 1'b0;
      mdu_start <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      mdu_start <= 1'b0;
    end else begin
      mdu_start <= accept && (dec_mul || dec_div);
      if (accept) begin
        out_valid <= 1'b1;
        alu_ctrl  <= CTRL_W'(dec_code);
        illegal   <= dec_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: driver issues directed and random
// instructions and queues expected words; a monitor pops on each transfer.
module tb_alu_ctrl_pipe;

  localparam int MUL_C = 4;
  localparam int DIV_C = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] aluop = 2'b00;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic       mdu_start;
  logic       mdu_busy;
  logic       stall;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(
    .CTRL_W      (4),
    .MUL_CYCLES  (MUL_C),
    .DIV_CYCLES  (DIV_C),
    .ILLEGAL_CODE(4'b0010)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .aluop    (aluop),
    .opcode   (opcode),
    .funct    (funct),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal),
    .mdu_start(mdu_start),
    .mdu_busy (mdu_busy),
    .stall    (stall)
  );

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
    logic       mdu;
    bit         shown;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: outstanding output word and remaining busy cycles.
  int   pending = 0;
  int   busy_left = 0;
  bit   model_ok = 0;
  bit   prev_rst = 0;

  logic [3:0] op_tab [logic [5:0]];
  logic [3:0] fn_tab [logic [5:0]];
  int         fn_cyc [logic [5:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] a, input logic [5:0] op, input logic [5:0] fn,
                                     output logic [3:0] c, output logic ill, output int cyc);
    c = 4'b0010;
    ill = 1'b1;
    cyc = 0;
    if (op != 6'd0) begin
      if (op_tab.exists(op)) begin
        c = op_tab[op];
        ill = 1'b0;
      end
    end else if (a == 2'b00) begin
      c = 4'b0010;
      ill = 1'b0;
    end else if (a == 2'b01) begin
      c = 4'b0110;
      ill = 1'b0;
    end else if (a == 2'b10 && fn_tab.exists(fn)) begin
      c = fn_tab[fn];
      ill = 1'b0;
      if (fn_cyc.exists(fn)) cyc = fn_cyc[fn];
    end
    if (ill) c = 4'b0010;
  endfunction

  task automatic step(input logic iv, input logic [1:0] a, input logic [5:0] op, input logic [5:0] fn,
                      input logic ordy, input logic fl, input logic rst);
    logic [3:0] c;
    logic       ill;
    int         cyc;
    bit         exp_rdy;
    exp_t       e;
    @(posedge clk);
    #1;
    in_valid = iv; aluop = a; opcode = op; funct = fn;
    out_ready = ordy; flush = fl; rst_n = rst;
    @(negedge clk);
    exp_rdy = (busy_left == 0) && (pending == 0 || ordy);
    if (model_ok) begin
      check("in_ready", in_ready, exp_rdy);
      check("stall", stall, !exp_rdy);
      check("mdu_busy", mdu_busy, busy_left > 0);
      check("out_valid", out_valid, pending != 0);
      if (prev_rst) begin
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_illegal", illegal, 0);
        check("rst_mdu_start", mdu_start, 0);
      end
    end
    prev_rst = !rst;
    if (!rst) begin
      pending = 0;
      busy_left = 0;
      model_ok = 1;
    end else if (fl) begin
      pending = 0;
      busy_left = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (pending != 0 && ordy) pending = 0;
      if (iv && exp_rdy) begin
        ref_decode(a, op, fn, c, ill, cyc);
        e.ctrl = c; e.ill = ill; e.mdu = (cyc > 0); e.shown = 0;
        sb.push_back(e);
        pending = 1;
        if (cyc > 0) busy_left = cyc - 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: compares each presented word on the cycle it transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=none at %0t", alu_ctrl, $time);
        end else begin
          if (!sb[0].shown) begin
            check("mdu_start", mdu_start, sb[0].mdu);
            sb[0].shown = 1;
          end else begin
            check("mdu_start_once", mdu_start, 0);
          end
          if (out_ready) begin
            check("alu_ctrl", alu_ctrl, sb[0].ctrl);
            check("illegal", illegal, sb[0].ill);
            void'(sb.pop_front());
          end else if (flush) begin
            void'(sb.pop_front());
          end
        end
      end else begin
        check("mdu_start_idle", mdu_start, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [16];
    logic [5:0] fns [10];
    logic [1:0] ra;
    logic [5:0] rop, rfn;
    int r;

    op_tab[6'b001000] = 4'b0010; op_tab[6'b100000] = 4'b0010; op_tab[6'b100001] = 4'b0010;
    op_tab[6'b100011] = 4'b0010; op_tab[6'b101000] = 4'b0010; op_tab[6'b101001] = 4'b0010;
    op_tab[6'b101011] = 4'b0010; op_tab[6'b111111] = 4'b0110; op_tab[6'b001100] = 4'b0000;
    op_tab[6'b001101] = 4'b0001; op_tab[6'b001010] = 4'b0111; op_tab[6'b001111] = 4'b1111;
    op_tab[6'b000001] = 4'b1110; op_tab[6'b000101] = 4'b1000; op_tab[6'b000100] = 4'b0110;
    fn_tab[6'b100000] = 4'b0010; fn_tab[6'b100010] = 4'b0110; fn_tab[6'b100100] = 4'b0000;
    fn_tab[6'b100101] = 4'b0001; fn_tab[6'b101010] = 4'b0111; fn_tab[6'b100111] = 4'b1100;
    fn_tab[6'b011000] = 4'b0011; fn_tab[6'b011001] = 4'b0011;
    fn_tab[6'b011010] = 4'b0100; fn_tab[6'b011011] = 4'b0100;
    fn_cyc[6'b011000] = MUL_C; fn_cyc[6'b011001] = MUL_C;
    fn_cyc[6'b011010] = DIV_C; fn_cyc[6'b011011] = DIV_C;
    ops = '{6'b001000, 6'b100000, 6'b100001, 6'b100011, 6'b101000, 6'b101001, 6'b101011,
            6'b111111, 6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b000001, 6'b000101,
            6'b000100, 6'b010000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111,
            6'b011000, 6'b011001, 6'b011010, 6'b011011};

    // Reset, then a short stream at full throughput.
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b00, 6'b001101, 6'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b00, 6'b100011, 6'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b01, 6'b000101, 6'd0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // mult then add offered every cycle; add must wait out the busy window.
    step(1'b1, 2'b10, 6'd0, 6'b011000, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Backpressure on sub.
    step(1'b1, 2'b10, 6'd0, 6'b100010, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Illegal decodes.
    step(1'b1, 2'b10, 6'b010000, 6'b100000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b11, 6'd0, 6'b100000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b10, 6'd0, 6'b111111, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Flush in the middle of a divide, with a competing input.
    step(1'b1, 2'b10, 6'd0, 6'b011010, 1'b1, 1'b0, 1'b1);
    idle(9);
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Reset in the middle of traffic.
    step(1'b1, 2'b10, 6'd0, 6'b011011, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic with backpressure and occasional flush/reset.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      ra = 2'b10; rop = 6'd0; rfn = fns[$urandom_range(0, 9)];
      if (r == 4) begin
        ra = 2'($urandom_range(0, 3));
        rfn = 6'($urandom);
      end else if (r >= 5 && r <= 7) begin
        ra = 2'($urandom_range(0, 3));
        rop = ops[$urandom_range(0, 15)];
      end else if (r == 8) begin
        rop = 6'($urandom);
      end else if (r == 9) begin
        ra = 2'b11;
      end
      step(1'($urandom_range(0, 9) < 7), ra, rop, rfn,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0),
           1'(!(i == 250 || i == 251)));
    end
    idle(40);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
Registered, parametrised ALU-control stage sitting between the ID/EX pipeline register and the ALU/MDU of the MIPS datapath. Decodes ALUOp, opcode and funct into an ALU control word, as the combinational decoder does. Adds:
- valid/ready handshake with a one-entry output register;
- multi-cycle multiply/divide sequencing with a busy counter and stall;
- flush;
- an illegal-instruction flag.

Parameters:
- CTRL_W, 4: ALU control width. Must be at least 4; codes below are zero-extended.
- MUL_CYCLES, 4: EX cycles occupied by mult/multu (1..255).
- DIV_CYCLES, 32: EX cycles occupied by div/divu (1..255).
- ILLEGAL_CODE, 4'b0010: control word driven when the decode is illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ID/EX presents an instruction
- in_ready  out  1  stage accepts this cycle
- aluop  in  2  ALUOp from main control
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- flush  in  1  kill held and in-flight entry (branch mispredict)
- out_valid  out  1  alu_ctrl is valid for EX
- out_ready  in  1  EX consumes output
- alu_ctrl  out  CTRL_W  ALU control word
- illegal  out  1  decode miss on accepted instruction
- mdu_start  out  1  one-cycle pulse starting mult/div
- mdu_busy  out  1  multi-cycle op in progress
- stall  out  1  equals !in_ready (to hazard unit)

Behaviour:

Reset (rst_n=0 at posedge), all outputs:
- out_valid=0, alu_ctrl=0, illegal=0, mdu_start=0, mdu_busy=0.
- State=IDLE, counter=0.
- Reset mid-MDU operation aborts it with no pulse or flag.

Decode priority, first match wins:
1. opcode≠000000: opcode table.
2. aluop=00: 0010.
3. aluop=01: 0110.
4. aluop=10: funct table.
5. Anything else (including aluop=11): illegal=1, alu_ctrl=ILLEGAL_CODE.

Opcode table:
- 001000 addi, 100000 lb, 100001 lh, 100011 lw, 101000 sb, 101001 sh, 101011 sw: 0010
- 111111 subi: 0110
- 001100 andi: 0000
- 001101 ori: 0001
- 001010 slti: 0111
- 001111 lui: 1111
- 000001 bgez: 1110
- 000101 bne: 1000
- 000100 beq: 0110
- Any other non-zero opcode: illegal.

Funct table:
- 100000 add: 0010
- 100010 sub: 0110
- 100100 and: 0000
- 100101 or: 0001
- 101010 slt: 0111
- 100111 nor: 1100
- 011000 mult, 011001 multu: 0011 (MUL class)
- 011010 div, 011011 divu: 0100 (DIV class)
- Other funct: illegal.

Handshake:
- Transfer occurs when in_valid && in_ready at posedge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Decoded result is registered; 1-cycle latency from accept to out_valid=1.
- Output holds stable while out_valid && !out_ready.
- Back-to-back accepts at full throughput when out_ready=1.

FSM:
- IDLE: accepting a MUL/DIV class instruction
  - loads counter with MUL_CYCLES-1 or DIV_CYCLES-1;
  - pulses mdu_start in the cycle out_valid first rises;
  - goes to BUSY if the loaded value is ≠0, otherwise stays IDLE.
- BUSY: mdu_busy=1, in_ready=0, counter decrements each cycle; at 0, returns to IDLE.
- out_valid for the MDU op behaves like any other op. It is independent of BUSY and can be consumed while BUSY continues.

Flush:
- Clears out_valid, illegal and mdu_start next edge.
- Forces IDLE and counter=0.
- Beats a simultaneous accept, which is dropped.

Illegal:
- illegal is registered alongside alu_ctrl and is valid only with out_valid.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode/funct localparams and ALU code localparams;
  - state encoding;
  - MUL/DIV class codes.
- One sub-module: alu_ctrl_decode, purely combinational; outputs code, is_mul, is_div, illegal.
- Top holds the output register, FSM and counter.

Test Plan:
- Reset with rst_n=0 for 2 cycles during traffic -> all outputs 0, in_ready=1 after release.
- Stream add, ori (001101), lw, bne with out_ready=1 -> alu_ctrl 0010, 0001, 0010, 1000 on consecutive cycles, each 1 cycle after accept.
- mult (aluop=10, funct=011000), MUL_CYCLES=4 -> alu_ctrl=0011, mdu_start one pulse, in_ready low exactly 3 cycles; a following add is accepted on the 4th cycle.
- Hold out_ready=0 for 3 cycles after accepting sub -> alu_ctrl=0110 held, in_ready=0, no new accept; releases on out_ready=1.
- opcode=010000 and aluop=11 -> illegal=1, alu_ctrl=0010.
- flush asserted mid-div (DIV_CYCLES=32, cycle 10) with in_valid=1 -> out_valid=0, mdu_busy=0 next cycle, that input not accepted, in_ready=1 the following cycle.
